// File: rtl/torv32_pkg.sv
// torv32_pkg: shared constants and the memory-arbiter owner encoding.
package torv32_pkg;

    localparam int ADDR_W       = 17;
    localparam int STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_D = 2'd1,
        OWN_F = 2'd2,
        OWN_L = 2'd3
    } owner_e;

endpackage

// File: rtl/mem_arb_age.sv
// mem_arb_age: saturating wait counter; starved_o flags a requester denied LIMIT cycles in a row.
module mem_arb_age #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic req_i,
    input  logic gnt_i,
    output logic starved_o
);

    logic [3:0] cnt_q, cnt_d;

    assign starved_o = cnt_q == 4'(LIMIT);
    assign cnt_d     = (!req_i || gnt_i) ? 4'd0 : starved_o ? cnt_q : cnt_q + 4'd1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cnt_q <= 4'd0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/torv32_mem_arb.sv
// torv32_mem_arb: one-RAM arbiter for data/fetch/loader, fixed priority with starvation aging.
// The loader port only arbitrates when TORV32_MEM_ARB_LOADER_EN is defined.
module torv32_mem_arb
    import torv32_pkg::*;
#(
    parameter int ADDR_W       = torv32_pkg::ADDR_W,
    parameter int STARVE_LIMIT = torv32_pkg::STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [3:0]        d_wmask,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    input  logic              l_req,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [3:0]        l_wmask,
    input  logic [31:0]       l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [31:0]       rdata,
    output logic              ram_en,
    output logic [ADDR_W-3:0] ram_addr,
    output logic [3:0]        ram_wmask,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    logic              f_starved, l_starved, l_req_v;
    logic [ADDR_W-1:0] addr_sel;
    owner_e            owner_q, owner_d;

    mem_arb_age #(.LIMIT(STARVE_LIMIT)) u_f_age (
        .clk       (clk),
        .resetn    (resetn),
        .req_i     (f_req),
        .gnt_i     (f_gnt),
        .starved_o (f_starved)
    );

`ifdef TORV32_MEM_ARB_LOADER_EN
    localparam bit LOADER_EN = 1'b1;
    mem_arb_age #(.LIMIT(STARVE_LIMIT)) u_l_age (
        .clk       (clk),
        .resetn    (resetn),
        .req_i     (l_req_v),
        .gnt_i     (l_gnt),
        .starved_o (l_starved)
    );
`else
    localparam bit LOADER_EN = 1'b0;
    assign l_starved = 1'b0;
`endif

    assign l_req_v = LOADER_EN && l_req;

    // Starved fetch outranks a starved loader, so a double saturation resolves fetch-then-loader.
    always_comb begin
        d_gnt = 1'b0;
        f_gnt = 1'b0;
        l_gnt = 1'b0;
        if (resetn) begin
            if (f_req && f_starved)        f_gnt = 1'b1;
            else if (l_req_v && l_starved) l_gnt = 1'b1;
            else if (d_req)                d_gnt = 1'b1;
            else if (f_req)                f_gnt = 1'b1;
            else                           l_gnt = l_req_v;
        end
    end

    assign ram_en    = d_gnt | f_gnt | l_gnt;
    assign addr_sel  = l_gnt ? l_addr : f_gnt ? f_addr : d_addr;
    assign ram_addr  = addr_sel[ADDR_W-1:2];
    assign ram_wmask = d_gnt ? d_wmask : l_gnt ? l_wmask : 4'b0000;
    assign ram_wdata = l_gnt ? l_wdata : d_wdata;

    assign owner_d = (ram_wmask != 4'b0000) ? IDLE :
                     d_gnt ? OWN_D : f_gnt ? OWN_F : l_gnt ? OWN_L : IDLE;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) owner_q <= IDLE;
        else         owner_q <= owner_d;
    end

    assign d_rvalid = owner_q == OWN_D;
    assign f_rvalid = owner_q == OWN_F;
    assign l_rvalid = owner_q == OWN_L;
    assign rdata    = ram_rdata;

endmodule

// File: tb/tb_torv32_mem_arb.sv
// tb_torv32_mem_arb: vector table plus arbitration sequences, read data tracked by a scoreboard.
module tb_torv32_mem_arb;

    localparam int AW = 17;
`ifdef TORV32_MEM_ARB_LOADER_EN
    localparam bit LD = 1'b1;
`else
    localparam bit LD = 1'b0;
`endif
    localparam logic [2:0] GD = 3'b100, GF = 3'b010, GL = 3'b001, G0 = 3'b000;

    logic          clk = 1'b0, resetn = 1'b0, ram_init = 1'b1;
    logic          d_req, f_req, l_req, d_gnt, f_gnt, l_gnt, d_rvalid, f_rvalid, l_rvalid, ram_en;
    logic [AW-1:0] d_addr, f_addr, l_addr;
    logic [3:0]    d_wmask, l_wmask, ram_wmask;
    logic [31:0]   d_wdata, l_wdata, rdata, ram_wdata, ram_rdata;
    logic [AW-3:0] ram_addr;

    always #5 clk = ~clk;

    torv32_mem_arb dut (
        .clk(clk), .resetn(resetn),
        .d_req(d_req), .d_addr(d_addr), .d_wmask(d_wmask), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
        .l_req(l_req), .l_addr(l_addr), .l_wmask(l_wmask), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid),
        .rdata(rdata), .ram_en(ram_en), .ram_addr(ram_addr), .ram_wmask(ram_wmask),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
        end else if (ram_en) begin
            ram_rdata <= mem[ram_addr[7:0]];
            for (int b = 0; b < 4; b++)
                if (ram_wmask[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    typedef struct {
        logic [2:0]  v;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic        dr, fr, lr;
        logic [3:0]  dm, lm;
        logic [16:0] da, fa, la;
        logic [31:0] dw, lw;
        logic [2:0]  eg;
        logic [14:0] ea;
        logic [3:0]  ewm;
    } vec_t;

    exp_t        sbq [$];
    logic [31:0] shadow [256];
    vec_t        vt [12];
    int          checks = 0, errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    task automatic drive(input logic dr, fr, lr, input logic [3:0] dm, lm,
                         input logic [16:0] da, fa, la, input logic [31:0] dw, lw);
        d_req = dr; f_req = fr; l_req = lr;
        d_wmask = dm; l_wmask = lm;
        d_addr = da; f_addr = fa; l_addr = la;
        d_wdata = dw; l_wdata = lw;
    endtask

    // Called just after a falling edge with inputs already driven for this cycle.
    task automatic tick(input logic [2:0] eg, input logic [14:0] ea, input logic [3:0] ewm,
                        input logic [31:0] wd, input string nm);
        exp_t e;
        #1;
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check({nm, " rvalid"}, 32'({d_rvalid, f_rvalid, l_rvalid}), 32'(e.v));
            if (e.v != G0) check({nm, " rdata"}, rdata, e.data);
        end else begin
            check({nm, " rvalid"}, 32'({d_rvalid, f_rvalid, l_rvalid}), 32'(0));
        end
        check({nm, " gnt"}, 32'({d_gnt, f_gnt, l_gnt}), 32'(eg));
        check({nm, " ram_en"}, 32'(ram_en), 32'(eg != G0));
        check({nm, " ram_wmask"}, 32'(ram_wmask), 32'(ewm));
        if (eg != G0) begin
            check({nm, " ram_addr"}, 32'(ram_addr), 32'(ea));
            if (ewm != 4'h0) begin
                check({nm, " ram_wdata"}, ram_wdata, wd);
                for (int b = 0; b < 4; b++)
                    if (ewm[b]) shadow[ea[7:0]][8*b +: 8] = wd[8*b +: 8];
            end else begin
                sbq.push_back('{eg, shadow[ea[7:0]]});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset(input string nm);
        #1;
        check({nm, " gnt"}, 32'({d_gnt, f_gnt, l_gnt}), 32'(0));
        check({nm, " rvalid"}, 32'({d_rvalid, f_rvalid, l_rvalid}), 32'(0));
        check({nm, " ram_en"}, 32'(ram_en), 32'(0));
        check({nm, " ram_wmask"}, 32'(ram_wmask), 32'(0));
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [2:0]  g;
        logic [14:0] ea;
        for (int i = 0; i < 256; i++) shadow[i] = 32'hC0DE_0000 | 32'(i);
        vt[0]  = '{1, 0, 0, 4'h0, 4'h0, 17'h10, 17'h0,  17'h0,  32'h0, 32'h0, GD, 15'h4, 4'h0};
        vt[1]  = '{0, 0, 0, 4'h0, 4'h0, 17'h0,  17'h0,  17'h0,  32'h0, 32'h0, G0, 15'h0, 4'h0};
        vt[2]  = '{1, 0, 0, 4'h4, 4'h0, 17'h20, 17'h0,  17'h0,  32'h00AB_0000, 32'h0, GD, 15'h8, 4'h4};
        vt[3]  = '{1, 0, 0, 4'h0, 4'h0, 17'h20, 17'h0,  17'h0,  32'h0, 32'h0, GD, 15'h8, 4'h0};
        vt[4]  = '{0, 1, 0, 4'h0, 4'h0, 17'h0,  17'h8,  17'h0,  32'h0, 32'h0, GF, 15'h2, 4'h0};
        vt[5]  = '{1, 1, 0, 4'h0, 4'h0, 17'h14, 17'h1C, 17'h0,  32'h0, 32'h0, GD, 15'h5, 4'h0};
        vt[6]  = '{0, 1, 0, 4'h0, 4'h0, 17'h0,  17'h1C, 17'h0,  32'h0, 32'h0, GF, 15'h7, 4'h0};
        vt[7]  = '{0, 0, 1, 4'h0, 4'h0, 17'h0,  17'h0,  17'h40, 32'h0, 32'h0, LD ? GL : G0, 15'h10, 4'h0};
        vt[8]  = '{0, 1, 1, 4'h0, 4'h0, 17'h0,  17'h4,  17'h44, 32'h0, 32'h0, GF, 15'h1, 4'h0};
        vt[9]  = '{0, 0, 1, 4'h0, 4'hF, 17'h0,  17'h0,  17'h30, 32'h0, 32'hDEAD_BEEF,
                   LD ? GL : G0, 15'hC, LD ? 4'hF : 4'h0};
        vt[10] = '{1, 0, 1, 4'h0, 4'h0, 17'h30, 17'h0,  17'h48, 32'h0, 32'h0, GD, 15'hC, 4'h0};
        vt[11] = '{0, 0, 0, 4'h0, 4'h0, 17'h0,  17'h0,  17'h0,  32'h0, 32'h0, G0, 15'h0, 4'h0};

        drive(1, 1, 1, 4'h0, 4'h0, 17'h10, 17'h20, 17'h30, 32'h0, 32'h0);
        @(negedge clk);
        chk_reset("reset");
        chk_reset("reset_hold");
        ram_init = 1'b0;
        resetn   = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(vt[i].dr, vt[i].fr, vt[i].lr, vt[i].dm, vt[i].lm,
                  vt[i].da, vt[i].fa, vt[i].la, vt[i].dw, vt[i].lw);
            tick(vt[i].eg, vt[i].ea, vt[i].ewm, vt[i].eg == GL ? vt[i].lw : vt[i].dw,
                 $sformatf("vec%0d", i));
        end

        // Data and fetch contend: four data grants, then one aged fetch grant.
        drive(1, 1, 0, 4'h0, 4'h0, 17'h50, 17'h60, 17'h0, 32'h0, 32'h0);
        for (int i = 0; i < 10; i++)
            tick(i % 5 == 4 ? GF : GD, i % 5 == 4 ? 15'h18 : 15'h14, 4'h0, 32'h0,
                 $sformatf("starve%0d", i));
        drive(0, 0, 0, 4'h0, 4'h0, 17'h0, 17'h0, 17'h0, 32'h0, 32'h0);
        tick(G0, 15'h0, 4'h0, 32'h0, "starve_end");

        drive(1, 1, 1, 4'h0, 4'h0, 17'h50, 17'h60, 17'h70, 32'h0, 32'h0);
        for (int i = 0; i < 15; i++) begin
            if (!LD)        g = (i % 5 == 4) ? GF : GD;
            else if (i < 4) g = GD;
            else if (i == 4) g = GF;
            else            g = ((i - 5) % 5 == 0) ? GL : ((i - 5) % 5 == 4) ? GF : GD;
            ea = g == GD ? 15'h14 : g == GF ? 15'h18 : 15'h1C;
            tick(g, ea, 4'h0, 32'h0, $sformatf("all3_%0d", i));
        end
        drive(0, 0, 0, 4'h0, 4'h0, 17'h0, 17'h0, 17'h0, 32'h0, 32'h0);
        tick(G0, 15'h0, 4'h0, 32'h0, "all3_end");

        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 4'h0, 4'h0, 17'h0, 17'(4 * i), 17'h0, 32'h0, 32'h0);
            tick(GF, 15'(i), 4'h0, 32'h0, $sformatf("b2b%0d", i));
        end
        drive(0, 0, 0, 4'h0, 4'h0, 17'h0, 17'h0, 17'h0, 32'h0, 32'h0);
        tick(G0, 15'h0, 4'h0, 32'h0, "b2b_end");

        // Reset lands while the fetch read is outstanding; its rvalid must vanish.
        drive(0, 1, 0, 4'h0, 4'h0, 17'h0, 17'hC, 17'h0, 32'h0, 32'h0);
        tick(GF, 15'h3, 4'h0, 32'h0, "rstA_gnt");
        d_req  = 1'b1;
        resetn = 1'b0;
        chk_reset("rstA");
        sbq.delete();
        chk_reset("rstA_hold");
        resetn = 1'b1;
        drive(0, 0, 0, 4'h0, 4'h0, 17'h0, 17'h0, 17'h0, 32'h0, 32'h0);
        tick(G0, 15'h0, 4'h0, 32'h0, "rstA_post");

        // Fetch has aged three cycles when reset hits; afterwards the count restarts at zero.
        drive(1, 1, 0, 4'h0, 4'h0, 17'h50, 17'h60, 17'h0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) tick(GD, 15'h14, 4'h0, 32'h0, $sformatf("rstB_pre%0d", i));
        resetn = 1'b0;
        chk_reset("rstB");
        sbq.delete();
        resetn = 1'b1;
        for (int i = 0; i < 5; i++)
            tick(i == 4 ? GF : GD, i == 4 ? 15'h18 : 15'h14, 4'h0, 32'h0,
                 $sformatf("rstB_post%0d", i));
        drive(0, 0, 0, 4'h0, 4'h0, 17'h0, 17'h0, 17'h0, 32'h0, 32'h0);
        tick(G0, 15'h0, 4'h0, 32'h0, "rstB_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
